// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: mult/multu in 1 busy cycle, div/divu in 33 busy cycles (32-step restoring divide + sign fix-up).
// No backpressure: requests are accepted only when idle and flush is low; requests seen while busy are dropped.
module mul_div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  MULT,
    input  logic [1:0]  DIV,
    input  logic [1:0]  MTHL,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_signed;
    logic [4:0]  r_cnt;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_acc_mul;
    logic        w_acc_div;
    logic        w_acc_hi;
    logic        w_acc_lo;
    logic        w_sel_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_mul   = 1'b0;
        w_acc_div   = 1'b0;
        w_acc_hi    = 1'b0;
        w_acc_lo    = 1'b0;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|MULT) begin
                        w_acc_mul   = 1'b1;
                        w_state_nxt = ST_MUL;
                    end else if (|DIV) begin
                        w_acc_div   = 1'b1;
                        w_state_nxt = ST_DIV;
                    end else if (MTHL[0]) begin
                        w_acc_lo = 1'b1;
                    end else if (MTHL[1]) begin
                        w_acc_hi = 1'b1;
                    end
                end
                ST_MUL:  w_state_nxt = ST_IDLE;
                ST_DIV:  w_state_nxt = (r_cnt == 5'd31) ? ST_FIX : ST_DIV;
                ST_FIX:  w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_sel_signed = w_acc_mul ? MULT[0] : DIV[0];
    assign w_a_mag      = (DIV[0] && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign w_b_mag      = (DIV[0] && src_b[31]) ? (32'd0 - src_b) : src_b;

    // Sign-extending to 64 bits makes one unsigned multiplier serve both mult and multu.
    assign w_mul_a = {{32{r_signed & r_a[31]}}, r_a};
    assign w_mul_b = {{32{r_signed & r_b[31]}}, r_b};
    assign w_prod  = w_mul_a * w_mul_b;

    assign w_rem_sh = {r_rem, r_quot[31]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};

    assign w_q_fix = (r_signed && (r_a[31] ^ r_b[31])) ? (32'd0 - r_quot) : r_quot;
    assign w_r_fix = (r_signed && r_a[31]) ? (32'd0 - r_rem) : r_rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_acc_mul || w_acc_div) begin
                r_a      <= src_a;
                r_b      <= src_b;
                r_signed <= w_sel_signed;
                r_cnt    <= '0;
                r_quot   <= w_a_mag;
                r_rem    <= '0;
                r_dvs    <= w_b_mag;
            end
            if (w_acc_hi) begin
                r_hi <= src_a;
            end
            if (w_acc_lo) begin
                r_lo <= src_a;
            end
            if (!flush) begin
                case (r_state)
                    ST_MUL: begin
                        r_hi   <= w_prod[63:32];
                        r_lo   <= w_prod[31:0];
                        r_done <= 1'b1;
                    end
                    ST_DIV: begin
                        r_cnt <= r_cnt + 5'd1;
                        if (!w_diff[32]) begin
                            r_rem  <= w_diff[31:0];
                            r_quot <= {r_quot[30:0], 1'b1};
                        end else begin
                            r_rem  <= w_rem_sh[31:0];
                            r_quot <= {r_quot[30:0], 1'b0};
                        end
                    end
                    ST_FIX: begin
                        // A zero divisor is reported as all-ones quotient and the untouched dividend.
                        if (r_b == 32'd0) begin
                            r_lo <= 32'hFFFF_FFFF;
                            r_hi <= r_a;
                        end else begin
                            r_lo <= w_q_fix;
                            r_hi <= w_r_fix;
                        end
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign busy = (r_state != ST_IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table of mult/div ops plus hand-written flush, mthi/mtlo and reset sequences.
module tb_mul_div_unit;

    logic        clk;
    logic        resetn;
    logic [1:0]  MULT;
    logic [1:0]  DIV;
    logic [1:0]  MTHL;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    mul_div_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .MULT   (MULT),
        .DIV    (DIV),
        .MTHL   (MTHL),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .HI     (HI),
        .LO     (LO),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mult;
        logic [1:0]  div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op, count busy cycles, then check done pulse and HI/LO.
    task automatic run_op(input string name, input logic [1:0] m, input logic [1:0] d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_cyc);
        int cyc;
        @(negedge clk);
        MULT = m; DIV = d; src_a = a; src_b = b;
        @(posedge clk);
        #1;
        MULT = 2'b00; DIV = 2'b00;
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk({name, " busy_cycles"}, cyc, exp_cyc);
        chk({name, " done"}, {31'd0, done}, 32'd1);
        chk({name, " HI"}, HI, exp_hi);
        chk({name, " LO"}, LO, exp_lo);
        @(negedge clk);
        chk({name, " done_off"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        vecs[0]  = '{2'b01, 2'b00, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1};
        vecs[1]  = '{2'b10, 2'b00, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 1};
        vecs[2]  = '{2'b01, 2'b00, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1};
        vecs[3]  = '{2'b10, 2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1};
        vecs[4]  = '{2'b10, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1};
        vecs[5]  = '{2'b01, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1};
        vecs[6]  = '{2'b11, 2'b01, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1};
        vecs[7]  = '{2'b00, 2'b01, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[8]  = '{2'b00, 2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[9]  = '{2'b00, 2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33};
        vecs[10] = '{2'b00, 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[11] = '{2'b00, 2'b01, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 33};
        vecs[12] = '{2'b00, 2'b01, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[13] = '{2'b00, 2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 33};
        vecs[14] = '{2'b00, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33};
        vecs[15] = '{2'b00, 2'b10, 32'h80000000, 32'd3,        32'd2,        32'h2AAAAAAA, 33};

        resetn = 1'b0; MULT = 2'b00; DIV = 2'b00; MTHL = 2'b00;
        src_a = '0; src_b = '0; flush = 1'b0;
        #3;
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].mult, vecs[i].div, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].cycles);
        end

        // mthi then mtlo on consecutive edges
        @(negedge clk);
        MTHL = 2'b10; src_a = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        MTHL = 2'b01; src_a = 32'h5A5A5A5A;
        @(negedge clk);
        chk("mthi HI", HI, 32'hA5A5A5A5);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        chk("mthi done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        MTHL = 2'b00;
        @(negedge clk);
        chk("mtlo LO", LO, 32'h5A5A5A5A);
        chk("mtlo HI", HI, 32'hA5A5A5A5);
        chk("mtlo busy", {31'd0, busy}, 32'd0);
        chk("mtlo done", {31'd0, done}, 32'd0);

        // preload HI/LO = 0x12345678, then flush a div at its 10th busy cycle
        MTHL = 2'b11; src_a = 32'h12345678;
        @(posedge clk);
        #1;
        MTHL = 2'b10;
        @(posedge clk);
        #1;
        MTHL = 2'b00;
        @(negedge clk);
        chk("preload HI", HI, 32'h12345678);
        chk("preload LO", LO, 32'h12345678);
        DIV = 2'b01; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk);
        #1;
        DIV = 2'b00;
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 9) begin
            cyc++;
            if (cyc == 3) begin
                MULT = 2'b01; src_a = 32'd3; src_b = 32'd3;
            end else begin
                MULT = 2'b00;
            end
            @(negedge clk);
        end
        chk("flush reached cycle10 busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush busy", {31'd0, busy}, 32'd0);
        chk("flush done", {31'd0, done}, 32'd0);
        chk("flush HI", HI, 32'h12345678);
        chk("flush LO", LO, 32'h12345678);
        repeat (35) begin
            @(negedge clk);
            if (done || busy) break;
        end
        chk("flush late done", {31'd0, done}, 32'd0);
        chk("flush late LO", LO, 32'h12345678);

        // request coincident with flush is dropped
        MULT = 2'b01; src_a = 32'd2; src_b = 32'd2; flush = 1'b1;
        @(posedge clk);
        #1;
        MULT = 2'b00; flush = 1'b0;
        @(negedge clk);
        chk("coflush busy", {31'd0, busy}, 32'd0);

        // flush while in MUL suppresses the write and done
        MULT = 2'b10; src_a = 32'd2; src_b = 32'd3;
        @(posedge clk);
        #1;
        MULT = 2'b00;
        @(negedge clk);
        chk("mulflush busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("mulflush done", {31'd0, done}, 32'd0);
        chk("mulflush LO", LO, 32'h12345678);
        chk("mulflush busy_off", {31'd0, busy}, 32'd0);

        // asynchronous reset mid-div
        DIV = 2'b10; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk);
        #1;
        DIV = 2'b00;
        repeat (5) @(negedge clk);
        chk("prereset busy", {31'd0, busy}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async reset HI", HI, 32'd0);
        chk("async reset LO", LO, 32'd0);
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset done", {31'd0, done}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op("post_reset divu", 2'b00, 2'b10, 32'd9, 32'd3, 32'd0, 32'd3, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 MULT  in  2  multiply request from the control unit: [1]=multu, [0]=mult.
REQ-005 DIV  in  2  divide request: [1]=divu, [0]=div.
REQ-006 MTHL  in  2  HI/LO write request: [1]=mthi, [0]=mtlo.
REQ-007 src_a  in  32  rs operand: multiplicand, dividend, or mthi/mtlo data.
REQ-008 src_b  in  32  rt operand: multiplier or divisor.
REQ-009 flush  in  1  exception/eret cancel of the in-flight operation.
REQ-010 HI  out  32  HI register, continuously visible for mfhi.
REQ-011 LO  out  32  LO register, continuously visible for mflo.
REQ-012 busy  out  1  high while an operation is in flight; upstream stalls mfhi/mflo/mult/div/mthi/mtlo on it.
REQ-013 done  out  1  one-cycle pulse signalling a completed mult/div write of HI/LO.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, FIX; busy = (state != IDLE).
REQ-015 Requests SHALL be accepted only in IDLE with flush low; requests seen while busy are ignored.
REQ-016 Acceptance priority: MULT over DIV over MTHL; if both bits of a field are set, the signed op applies.
REQ-017 Accept at edge t SHALL register src_a/src_b and the signed flag.
REQ-018 MULT accept SHALL move to MUL; at edge t+1, {HI,LO} SHALL be written with the 64-bit product (two's-complement if signed, else unsigned), and the block SHALL return to IDLE.
REQ-019 DIV accept SHALL move to DIV with iteration counter 0; operands are the magnitudes when signed, else raw.
REQ-020 DIV SHALL perform one restoring shift/subtract quotient bit per edge for 32 edges (t+1..t+32), then enter FIX.
REQ-021 At edge t+33 FIX SHALL write LO = quotient, negated if signed and operand signs differ, and HI = remainder, negated if signed and src_a is negative; then IDLE. busy is high for exactly 33 cycles.
REQ-022 Divisor zero: timing SHALL be unchanged, with LO=32'hFFFFFFFF and HI=src_a, for both div and divu.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-024 MTHL accept SHALL write HI (mthi) or LO (mtlo) with src_a at edge t; it SHALL NOT assert busy or done.
REQ-025 done SHALL be high for exactly the one cycle following the HI/LO-writing edge of a mult or div (busy already low in that cycle).
REQ-026 flush high at any edge SHALL force IDLE, discard the in-flight result, leave HI/LO unchanged, and suppress done; a request coincident with flush is dropped.
REQ-027 HI/LO SHALL change only at the edges named in REQ-018/021/024.

Reset
REQ-028 resetn low SHALL immediately force state=IDLE, counter=0, HI=0, LO=0, busy=0, done=0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL abort it with no HI/LO write; the first request is accepted at the first edge after resetn rises.

Verification
REQ-030 mult, src_a=0xFFFFFFFF, src_b=2 -> after 1 busy cycle, HI=0xFFFFFFFF, LO=0xFFFFFFFE, done pulse; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 div, src_a=0xFFFFFFF9 (-7), src_b=2 -> busy for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF, done one cycle.
REQ-032 divu, 100/7 -> LO=14, HI=2; divu, 5/0 -> LO=0xFFFFFFFF, HI=5 after 33 busy cycles.
REQ-033 div started with HI=LO=0x12345678 and flush at the 10th busy cycle -> busy low next cycle, no done, HI/LO still 0x12345678; mult issued during busy -> ignored.
REQ-034 mthi 0xA5A5A5A5 then mtlo 0x5A5A5A5A on consecutive cycles -> HI/LO updated at those edges, busy and done stay 0.
REQ-035 resetn pulsed low mid-div -> HI=LO=0 and busy=0 without a clock edge; next divu 9/3 -> LO=3, HI=0.
